// File: rtl/des_key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des_key_sched_ctrl                                           |
// | Description : Iterative DES key-schedule controller. Applies PC-1 once on  |
// |               key load, keeps the permuted key, and hands one 48-bit round |
// |               subkey per handshake to the round datapath in encrypt order  |
// |               (K1..K16) or decrypt order (K16..K1).                        |
// | Options     : KEY_PARITY_CHECK_EN - reject key loads whose bytes do not    |
// |               all have odd parity and flag them on parity_err.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
//
// Bit numbering: key[63:0] holds FIPS key bits 1..64 with FIPS bit b at
// key[64-b]. The 56-bit permuted value keeps FIPS bit k at [56-k], so C is
// [55:28] and D is [27:0]; a FIPS "rotate left" moves bits toward the MSB.
//
// round_num is 4 bits wide, so FIPS round 16 is presented as 4'd0 while
// subkey_valid is high; last_round/direction tell it apart from "not valid".

module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key,
  input  logic        rerun,
  input  logic        decrypt,
  input  logic        abort,
  input  logic        round_req,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic        last_round,
  output logic        busy,
  output logic        done,
  output logic        key_valid,
  output logic        parity_err
);

  // PC-1: output bit k (1..56) takes FIPS key bit c_pc1[k-1]
  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: subkey bit k (1..48) takes bit c_pc2[k-1] of {C,D}
  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit r-1 set when FIPS round r shifts by two (rounds 1, 2, 9, 16 shift by one)
  localparam logic [15:0] c_shift_two = 16'h7EFC;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [55:0] r_base;
  logic [55:0] r_cd;
  logic [4:0]  r_cnt;
  logic        r_dir;
  logic        r_valid;
  logic        r_done;
  logic        r_key_valid;
  logic [47:0] r_subkey;

  logic [55:0] w_key_pc1;
  logic [55:0] w_base_sel;
  logic [27:0] w_c_base;
  logic [27:0] w_d_base;
  logic [55:0] w_cd_start;
  logic [27:0] w_c_cur;
  logic [27:0] w_d_cur;
  logic [27:0] w_c_step;
  logic [27:0] w_d_step;
  logic [55:0] w_cd_new;
  logic [47:0] w_subkey_new;
  logic [3:0]  w_shift_idx;
  logic        w_shift_two;

  logic        w_hs;
  logic        w_load_try;
  logic        w_parity_ok;
  logic        w_start;
  logic        w_load_accept;
  logic        w_advance;
  logic        w_finish;
  logic        w_stop;

  // ---------------------------------------------------------------------------
  // Fixed permutations (pure wiring)
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign w_key_pc1[55-gi] = key[64-c_pc1[gi]];
    end
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign w_subkey_new[47-gi] = w_cd_new[56-c_pc2[gi]];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional key parity check
  // ---------------------------------------------------------------------------
`ifdef KEY_PARITY_CHECK_EN
  logic [7:0] w_byte_odd;
  logic       r_parity_err;

  generate
    for (genvar gb = 0; gb < 8; gb++) begin : g_parity
      assign w_byte_odd[gb] = ^key[8*gb+7 : 8*gb];
    end
  endgenerate

  assign w_parity_ok = &w_byte_odd;

  // Every key_load evaluated in IDLE refreshes the parity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_load_try) begin
      r_parity_err <= ~w_parity_ok;
    end
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_parity_bits;

  // The parity bits only matter to the parity check
  assign w_unused_parity_bits = ^{key[56], key[48], key[40], key[32],
                                  key[24], key[16], key[8],  key[0]};
  assign w_parity_ok          = 1'b1;
  assign parity_err           = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Start value: a fresh load bypasses r_base so the first subkey is ready in
  // the very next cycle. Decrypt starts at C16/D16, which equals C0/D0.
  // ---------------------------------------------------------------------------
  assign w_base_sel = w_load_accept ? w_key_pc1 : r_base;
  assign w_c_base   = w_base_sel[55:28];
  assign w_d_base   = w_base_sel[27:0];
  assign w_cd_start = decrypt ? w_base_sel
                              : {w_c_base[26:0], w_c_base[27],
                                 w_d_base[26:0], w_d_base[27]};

  assign w_c_cur = r_cd[55:28];
  assign w_d_cur = r_cd[27:0];

  // Per-handshake rotation: the amount belongs to the round about to be presented
  always_comb begin
    w_shift_idx = r_dir ? (4'd15 - r_cnt[3:0]) : (r_cnt[3:0] + 4'd1);
    w_shift_two = c_shift_two[w_shift_idx];
    w_c_step    = w_c_cur;
    w_d_step    = w_d_cur;
    case ({r_dir, w_shift_two})
      2'b00: begin
        w_c_step = {w_c_cur[26:0], w_c_cur[27]};
        w_d_step = {w_d_cur[26:0], w_d_cur[27]};
      end
      2'b01: begin
        w_c_step = {w_c_cur[25:0], w_c_cur[27:26]};
        w_d_step = {w_d_cur[25:0], w_d_cur[27:26]};
      end
      2'b10: begin
        w_c_step = {w_c_cur[0], w_c_cur[27:1]};
        w_d_step = {w_d_cur[0], w_d_cur[27:1]};
      end
      default: begin
        w_c_step = {w_c_cur[1:0], w_c_cur[27:2]};
        w_d_step = {w_d_cur[1:0], w_d_cur[27:2]};
      end
    endcase
  end

  assign w_cd_new = w_start ? w_cd_start : {w_c_step, w_d_step};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign w_hs       = r_valid & round_req;
  assign w_load_try = (r_state == S_IDLE) & key_load & ~abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes; abort outranks any handshake in RUN
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_load_accept = 1'b0;
    w_advance     = 1'b0;
    w_finish      = 1'b0;
    w_stop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load_try) begin
          if (w_parity_ok) begin
            w_load_accept = 1'b1;
            w_start       = 1'b1;
            w_state_next  = S_RUN;
          end
        end else if (rerun && r_key_valid) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_stop       = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_hs) begin
          if (r_cnt == 5'd15) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Stored key, working C/D halves, counter and presented subkey
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_cd        <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
      r_subkey    <= '0;
    end else begin
      r_done <= w_finish;
      if (w_load_accept) begin
        r_base      <= w_key_pc1;
        r_key_valid <= 1'b1;
      end
      if (w_start) begin
        r_cd     <= w_cd_new;
        r_subkey <= w_subkey_new;
        r_cnt    <= 5'd0;
        r_dir    <= decrypt;
        r_valid  <= 1'b1;
      end else if (w_advance) begin
        r_cd     <= w_cd_new;
        r_subkey <= w_subkey_new;
        r_cnt    <= r_cnt + 5'd1;
      end else if (w_finish) begin
        r_cnt   <= 5'd16;
        r_valid <= 1'b0;
      end else if (w_stop) begin
        r_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign subkey       = r_subkey;
  assign subkey_valid = r_valid;
  assign round_num    = r_valid ? (r_dir ? (4'd0 - r_cnt[3:0]) : (r_cnt[3:0] + 4'd1))
                                : 4'd0;
  assign last_round   = r_valid & (r_cnt == 5'd15);
  assign busy         = (r_state == S_RUN);
  assign done         = r_done;
  assign key_valid    = r_key_valid;

endmodule

`default_nettype wire
